maxpool2d_2x2_stride2: RTL and testbench

//   Streaming 2x2/stride-2 max-pool for all channels of the conv+BN+ReLU layer output.

---
 rtl/maxpool2d_2x2_stride2.sv | 113 +++++++++++
 tb/tb_maxpool2d_2x2_stride2.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2d_2x2_stride2.sv
// Streaming 2x2 / stride-2 max-pool over a raster-ordered, channel-packed pixel stream.
// Horizontal pair maxima of even rows are parked in a half-width line buffer.
module maxpool2d_2x2_stride2 #(
    parameter int DATA_WIDHT = 32,
    parameter int CHANNELS   = 8,
    parameter int IMG_WIDTH  = 218,
    parameter int IMG_HEIGHT = 218
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDHT*CHANNELS-1:0] Data_In,
    input  logic                           Valid_In,
    output logic [DATA_WIDHT*CHANNELS-1:0] Data_Out,
    output logic                           Valid_Out,
    output logic                           Frame_Done
);

    localparam int PW     = DATA_WIDHT * CHANNELS;
    localparam int HALF_W = IMG_WIDTH / 2;
    localparam int CW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int AW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_END  = CW'(2 * HALF_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_END  = RW'(2 * (IMG_HEIGHT / 2) - 1);

    localparam logic [DATA_WIDHT-1:0] SIGN = {1'b1, {(DATA_WIDHT-1){1'b0}}};

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [PW-1:0] pair;
    logic [PW-1:0] h;
    logic [PW-1:0] pooled;
    logic [PW-1:0] lb_rd;
    logic [AW-1:0] lb_idx;
    logic          row_in_pairs;
    logic          lb_we;

    logic [PW-1:0] line_buf [HALF_W];

    // Maps a float to a key whose unsigned order is the float total order.
    function automatic logic [DATA_WIDHT-1:0] okey(input logic [DATA_WIDHT-1:0] x);
        return x[DATA_WIDHT-1] ? ~x : (x | SIGN);
    endfunction

    // Larger key wins; on a tie the first operand is kept.
    function automatic logic [DATA_WIDHT-1:0] fmax(
        input logic [DATA_WIDHT-1:0] a,
        input logic [DATA_WIDHT-1:0] b
    );
        return (okey(b) > okey(a)) ? b : a;
    endfunction

    assign lb_idx       = AW'(col >> 1);
    assign lb_rd        = line_buf[lb_idx];
    // A trailing row of an odd-height frame has no partner and is dropped.
    assign row_in_pairs = (row <= ROW_END);
    assign lb_we        = Valid_In && col[0] && !row[0] && row_in_pairs;

    // Per-channel horizontal max and final 2x2 max.
    always_comb begin
        h      = '0;
        pooled = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            h[k*DATA_WIDHT +: DATA_WIDHT] =
                fmax(pair[k*DATA_WIDHT +: DATA_WIDHT],
                     Data_In[k*DATA_WIDHT +: DATA_WIDHT]);
            pooled[k*DATA_WIDHT +: DATA_WIDHT] =
                fmax(lb_rd[k*DATA_WIDHT +: DATA_WIDHT],
                     h[k*DATA_WIDHT +: DATA_WIDHT]);
        end
    end

    // Line buffer write; contents need no reset since reads follow writes.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            line_buf[lb_idx] <= h;
        end
    end

    // Raster counters, pair register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            pair       <= '0;
            Data_Out   <= '0;
            Valid_Out  <= 1'b0;
            Frame_Done <= 1'b0;
        end else begin
            Valid_Out  <= 1'b0;
            Frame_Done <= 1'b0;
            if (Valid_In) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (!col[0]) begin
                    pair <= Data_In;
                end else if (row[0]) begin
                    Data_Out   <= pooled;
                    Valid_Out  <= 1'b1;
                    Frame_Done <= (col == COL_END) && (row == ROW_END);
                end
            end
        end
    end

endmodule

// File: tb/tb_maxpool2d_2x2_stride2.sv
// Bench for maxpool2d_2x2_stride2: window-level reference model plus
// literal expectations on small frames and a default-size frame count.
module tb_maxpool2d_2x2_stride2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [255:0] din     [3];
    logic         vin     [3];
    logic         drv_win [3];
    logic         acc_win [3];

    logic [63:0]  do_a, do_b;
    logic [255:0] do_c;
    logic         vo_a, vo_b, vo_c;
    logic         fd_a, fd_b, fd_c;

    int tests = 0;
    int fails = 0;
    int vcnt  [3];
    int fdcnt [3];

    logic [256:0] expq   [3][$];
    logic [255:0] cap    [3][$];
    logic [255:0] last_d [3];
    logic [255:0] img    [];

    maxpool2d_2x2_stride2 #(
        .DATA_WIDHT(32), .CHANNELS(2), .IMG_WIDTH(4), .IMG_HEIGHT(4)
    ) u_a (
        .clk(clk), .rst(rst), .Data_In(din[0][63:0]), .Valid_In(vin[0]),
        .Data_Out(do_a), .Valid_Out(vo_a), .Frame_Done(fd_a)
    );

    maxpool2d_2x2_stride2 #(
        .DATA_WIDHT(32), .CHANNELS(2), .IMG_WIDTH(5), .IMG_HEIGHT(5)
    ) u_b (
        .clk(clk), .rst(rst), .Data_In(din[1][63:0]), .Valid_In(vin[1]),
        .Data_Out(do_b), .Valid_Out(vo_b), .Frame_Done(fd_b)
    );

    maxpool2d_2x2_stride2 u_c (
        .clk(clk), .rst(rst), .Data_In(din[2]), .Valid_In(vin[2]),
        .Data_Out(do_c), .Valid_Out(vo_c), .Frame_Done(fd_c)
    );

    task automatic chk(input string nm, input int id,
                       input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s dut=%0d got=%h exp=%h t=%0t",
                     nm, id, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] okey(input logic [31:0] x);
        return x[31] ? ~x : (x | 32'h8000_0000);
    endfunction

    // Max of a 2x2 window per channel, operands in raster order.
    function automatic logic [255:0] win_max(input logic [255:0] a,
        input logic [255:0] b, input logic [255:0] c, input logic [255:0] d);
        logic [255:0] r;
        logic [31:0]  v [4];
        logic [31:0]  m;
        for (int k = 0; k < 8; k++) begin
            v[0] = a[k*32 +: 32];
            v[1] = b[k*32 +: 32];
            v[2] = c[k*32 +: 32];
            v[3] = d[k*32 +: 32];
            m = v[0];
            for (int j = 1; j < 4; j++)
                if (okey(v[j]) > okey(m)) m = v[j];
            r[k*32 +: 32] = m;
        end
        return r;
    endfunction

    function automatic logic [31:0] int_to_f32(input int n);
        int          e;
        logic [31:0] mm;
        if (n == 0) return 32'h0;
        e = 0;
        while ((n >> (e + 1)) != 0) e++;
        mm = 32'(n) << (23 - e);
        return {1'b0, 8'(127 + e), mm[22:0]};
    endfunction

    // Remember whether the pixel taken at this edge closed a window.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) acc_win[i] <= drv_win[i];
    end

    // Single compare process over all three instances.
    always @(negedge clk) begin : cmp
        logic         v, fd;
        logic [255:0] d;
        logic [256:0] e;
        for (int id = 0; id < 3; id++) begin
            case (id)
                0: begin v = vo_a; fd = fd_a; d = {192'b0, do_a}; end
                1: begin v = vo_b; fd = fd_b; d = {192'b0, do_b}; end
                default: begin v = vo_c; fd = fd_c; d = do_c; end
            endcase
            if (rst) begin
                chk("reset_data", id, d, '0);
                chk("reset_flags", id, {v, fd}, '0);
                last_d[id] = '0;
            end else begin
                chk("valid_timing", id, v, acc_win[id]);
                if (v) begin
                    vcnt[id]++;
                    if (fd) fdcnt[id]++;
                    cap[id].push_back(d);
                    if (expq[id].size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL extra_output dut=%0d got=%h", id, d);
                    end else begin
                        e = expq[id].pop_front();
                        chk("data", id, d, e[255:0]);
                        chk("frame_done", id, fd, e[256]);
                        last_d[id] = e[255:0];
                    end
                end else begin
                    chk("data_hold", id, d, last_d[id]);
                    chk("frame_done_idle", id, fd, '0);
                end
            end
        end
    end

    task automatic idle(input int id, input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            vin[id]     = 1'b0;
            drv_win[id] = 1'b0;
            din[id]     = {8{$urandom}};
            if (id < 2) din[id][255:64] = '0;
        end
    endtask

    task automatic send_frame(input int id, input int w, input int h,
                              input int npix, input int gapmax);
        int           n;
        int           r, c;
        logic         win, fd;
        logic [255:0] e;
        n = (npix < 0) ? w * h : npix;
        for (int p = 0; p < n; p++) begin
            r   = p / w;
            c   = p % w;
            win = (r % 2 == 1) && (c % 2 == 1) &&
                  (r < 2 * (h / 2)) && (c < 2 * (w / 2));
            fd  = (r == 2 * (h / 2) - 1) && (c == 2 * (w / 2) - 1);
            @(posedge clk);
            #1;
            din[id]     = img[p];
            vin[id]     = 1'b1;
            drv_win[id] = win;
            if (win) begin
                e = win_max(img[p-w-1], img[p-w], img[p-1], img[p]);
                expq[id].push_back({fd, e});
            end
            if (gapmax > 0) idle(id, $urandom_range(gapmax, 0));
        end
    endtask

    task automatic fill_index(input int w, input int h);
        logic [31:0] t;
        img = new[w * h];
        for (int p = 0; p < w * h; p++) begin
            t = int_to_f32(p);
            img[p] = '0;
            img[p][31:0]  = t;
            img[p][63:32] = {1'b1, t[30:0]};
        end
    endtask

    task automatic lit4(input int id, input int ch, input logic [31:0] a,
        input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
        logic [31:0]  ex [4];
        logic [255:0] g;
        ex = '{a, b, c, d};
        chk("out_count", id, cap[id].size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < cap[id].size()) begin
                g = cap[id][i];
                chk("literal", id, g[ch*32 +: 32], ex[i]);
            end
        end
    endtask

    initial begin
        int v0, f0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din[i] = '0;
            vin[i] = 1'b0;
            drv_win[i] = 1'b0;
            last_d[i] = '0;
            vcnt[i] = 0;
            fdcnt[i] = 0;
        end
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Index frame, continuous
        fill_index(4, 4);
        cap[0].delete();
        send_frame(0, 4, 4, -1, 0);
        idle(0, 3);
        lit4(0, 0, 32'h40A0_0000, 32'h40E0_0000, 32'h4150_0000, 32'h4170_0000);
        lit4(0, 1, 32'h8000_0000, 32'hC000_0000, 32'hC100_0000, 32'hC120_0000);

        // Same frame with idle gaps
        cap[0].delete();
        send_frame(0, 4, 4, -1, 3);
        idle(0, 3);
        lit4(0, 0, 32'h40A0_0000, 32'h40E0_0000, 32'h4150_0000, 32'h4170_0000);
        lit4(0, 1, 32'h8000_0000, 32'hC000_0000, 32'hC100_0000, 32'hC120_0000);

        // Odd 5x5 frame
        fill_index(5, 5);
        cap[1].delete();
        send_frame(1, 5, 5, -1, 0);
        idle(1, 3);
        lit4(1, 0, 32'h40C0_0000, 32'h4100_0000, 32'h4180_0000, 32'h4190_0000);

        // Signed zeros and negatives
        img = new[16];
        for (int p = 0; p < 16; p++) begin
            img[p] = '0;
            img[p][63:32] = $urandom;
        end
        img[0][31:0] = 32'h0000_0000;
        img[1][31:0] = 32'h8000_0000;
        img[4][31:0] = 32'hBF80_0000;
        img[5][31:0] = 32'h8000_0000;
        img[2][31:0] = 32'hC060_0000;
        img[3][31:0] = 32'hBFA0_0000;
        img[6][31:0] = 32'hC000_0000;
        img[7][31:0] = 32'hC100_0000;
        cap[0].delete();
        send_frame(0, 4, 4, -1, 1);
        idle(0, 3);
        lit4(0, 0, 32'h0000_0000, 32'hBFA0_0000, 32'h0000_0000, 32'h0000_0000);

        // Reset mid-frame, then a fresh frame
        fill_index(4, 4);
        send_frame(0, 4, 4, 6, 0);
        idle(0, 2);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        cap[0].delete();
        send_frame(0, 4, 4, -1, 0);
        idle(0, 3);
        lit4(0, 0, 32'h40A0_0000, 32'h40E0_0000, 32'h4150_0000, 32'h4170_0000);

        // Two frames back to back
        v0 = vcnt[0];
        f0 = fdcnt[0];
        send_frame(0, 4, 4, -1, 0);
        send_frame(0, 4, 4, -1, 0);
        idle(0, 3);
        chk("b2b_outputs", 0, vcnt[0] - v0, 8);
        chk("b2b_frame_done", 0, fdcnt[0] - f0, 2);

        // Default-size frame with random data
        img = new[218 * 218];
        for (int p = 0; p < 218 * 218; p++) img[p] = {8{$urandom}};
        v0 = vcnt[2];
        f0 = fdcnt[2];
        send_frame(2, 218, 218, -1, 0);
        idle(2, 3);
        chk("full_outputs", 2, vcnt[2] - v0, 11881);
        chk("full_frame_done", 2, fdcnt[2] - f0, 1);

        for (int i = 0; i < 3; i++) chk("missing_outputs", i, expq[i].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
